// File: rtl/mv_pkg.sv
// Shared types and constants for the motion-vector decision block.
// Field widths, FSM state codes, the packed row-result word and the
// position-to-displacement helper used when presenting the final vector.
package mv_pkg;

  localparam int SAD_W        = 12;
  localparam int POS_W        = 4;
  localparam int NUM_ROWS_DEF = 16;
  localparam int ORIGIN_DEF   = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } row_word_t;

  // Position relative to the zero-displacement origin, as a signed
  // POS_W+1 bit value (two's complement in a plain logic vector).
  function automatic logic [POS_W:0] to_disp(input logic [POS_W-1:0] pos,
                                             input int               origin);
    to_disp = {1'b0, pos} - (POS_W+1)'(origin);
  endfunction

endpackage

// File: rtl/mv_min2.sv
// Two-input minimum selector on the SAD field (combinational).
// Ports: best / cand row words in; win = selected word, take = cand wins.
// Strict less-than so that on a tie the earlier (best) word is kept.
module mv_min2
  import mv_pkg::*;
(
  input  row_word_t best,
  input  row_word_t cand,
  output row_word_t win,
  output logic      take
);

  assign take = (cand.sad < best.sad);
  assign win  = take ? cand : best;

endmodule

// File: rtl/mv_decision.sv
// Reduces NUM_ROWS per-row best-match words to the macroblock minimum and
// presents {dx, dy, sad} on mv_valid/mv_ready; mv_valid rises 1 clk after the
// last row word and the result is held until accepted (start is ignored while
// an unaccepted result is pending).
// Ports: clk/rst (async high); start, in_valid/in_data {sad,x,y}; mv_ready;
//        mv_valid, mv_dx, mv_dy, mv_sad; busy; err_stray, err_seq pulses.
module mv_decision
  import mv_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int ORIGIN   = ORIGIN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [SAD_W+2*POS_W-1:0] in_data,
  input  logic                     mv_ready,
  output logic                     mv_valid,
  output logic [POS_W:0]           mv_dx,
  output logic [POS_W:0]           mv_dy,
  output logic [SAD_W-1:0]         mv_sad,
  output logic                     busy,
  output logic                     err_stray,
  output logic                     err_seq
);

  localparam row_word_t BEST_INIT = '{sad: '1, x: '0, y: '0};
  localparam logic [POS_W-1:0] LAST_ROW = POS_W'(NUM_ROWS - 1);

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] row_cnt_q, row_cnt_d;
  row_word_t        best_q, best_d;
  logic             mv_valid_q, mv_valid_d;
  logic [POS_W:0]   mv_dx_q, mv_dx_d;
  logic [POS_W:0]   mv_dy_q, mv_dy_d;
  logic [SAD_W-1:0] mv_sad_q, mv_sad_d;
  logic             busy_q, busy_d;
  logic             err_stray_q, err_stray_d;
  logic             err_seq_q, err_seq_d;

  row_word_t cand;
  row_word_t win;
  logic      take;

  assign cand = row_word_t'(in_data);

  mv_min2 u_min2 (
    .best (best_q),
    .cand (cand),
    .win  (win),
    .take (take)
  );

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    best_d      = best_q;
    mv_dx_d     = mv_dx_q;
    mv_dy_d     = mv_dy_q;
    mv_sad_d    = mv_sad_q;
    err_stray_d = 1'b0;
    err_seq_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // A word arriving with start is still dropped; collection opens next cycle.
        err_stray_d = in_valid;
        if (start) begin
          state_d   = COLLECT;
          row_cnt_d = '0;
          best_d    = BEST_INIT;
        end
      end
      COLLECT: begin
        if (start) begin
          // Abort: discard partial minimum, no result is produced.
          row_cnt_d = '0;
          best_d    = BEST_INIT;
        end else if (in_valid) begin
          best_d    = win;
          row_cnt_d = row_cnt_q + 1'b1;
          err_seq_d = (cand.y != row_cnt_q);
          if (row_cnt_q == LAST_ROW) begin
            state_d  = HOLD;
            mv_dx_d  = to_disp(win.x, ORIGIN);
            mv_dy_d  = to_disp(win.y, ORIGIN);
            mv_sad_d = win.sad;
          end
        end
      end
      HOLD: begin
        err_stray_d = in_valid;
        // mv_valid is high for the whole of HOLD, so mv_ready alone is the accept.
        if (mv_ready) begin
          if (start) begin
            state_d   = COLLECT;
            row_cnt_d = '0;
            best_d    = BEST_INIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mv_valid_d = (state_d == HOLD);
    busy_d     = (state_d == COLLECT);
  end

  // take is only a diagnostic of the selector; the winner already encodes it.
  logic unused_take;
  assign unused_take = take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      best_q      <= BEST_INIT;
      mv_valid_q  <= 1'b0;
      mv_dx_q     <= '0;
      mv_dy_q     <= '0;
      mv_sad_q    <= '0;
      busy_q      <= 1'b0;
      err_stray_q <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      best_q      <= best_d;
      mv_valid_q  <= mv_valid_d;
      mv_dx_q     <= mv_dx_d;
      mv_dy_q     <= mv_dy_d;
      mv_sad_q    <= mv_sad_d;
      busy_q      <= busy_d;
      err_stray_q <= err_stray_d;
      err_seq_q   <= err_seq_d;
    end
  end

  assign mv_valid  = mv_valid_q;
  assign mv_dx     = mv_dx_q;
  assign mv_dy     = mv_dy_q;
  assign mv_sad    = mv_sad_q;
  assign busy      = busy_q;
  assign err_stray = err_stray_q;
  assign err_seq   = err_seq_q;

endmodule

// File: tb/tb_mv_decision.sv
// Self-checking bench for mv_decision: directed scenarios plus random traffic,
// compared every cycle against a behavioural model that keeps the accepted
// row words of the current search in queues and takes the minimum at the end.
module tb_mv_decision;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [19:0] in_data;
  logic        mv_ready;
  logic        mv_valid;
  logic [4:0]  mv_dx;
  logic [4:0]  mv_dy;
  logic [11:0] mv_sad;
  logic        busy;
  logic        err_stray;
  logic        err_seq;

  always #5 clk = ~clk;

  mv_decision #(.NUM_ROWS(NR), .ORIGIN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .mv_ready  (mv_ready),
    .mv_valid  (mv_valid),
    .mv_dx     (mv_dx),
    .mv_dy     (mv_dy),
    .mv_sad    (mv_sad),
    .busy      (busy),
    .err_stray (err_stray),
    .err_seq   (err_seq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: 0 idle, 1 collecting, 2 result pending ----
  int m_st;
  int q_sad[$];
  int q_x[$];
  int q_y[$];
  int e_sad, e_dx, e_dy;
  bit e_stray, e_seq;
  int seq_pulses;
  int valid_rises;

  function automatic void m_clear();
    q_sad.delete();
    q_x.delete();
    q_y.delete();
  endfunction

  function automatic void m_result();
    int bs, bx, by;
    bs = 4095; bx = 0; by = 0;
    foreach (q_sad[i]) begin
      if (q_sad[i] < bs) begin
        bs = q_sad[i]; bx = q_x[i]; by = q_y[i];
      end
    end
    e_sad = bs;
    e_dx  = bx - 8;
    e_dy  = by - 8;
  endfunction

  function automatic void m_step(input bit s, input bit v, input int sad, input int x,
                                 input int y, input bit r);
    e_stray = 1'b0;
    e_seq   = 1'b0;
    case (m_st)
      0: begin
        e_stray = v;
        if (s) begin m_st = 1; m_clear(); end
      end
      1: begin
        if (s) m_clear();
        else if (v) begin
          e_seq = (y != q_sad.size());
          q_sad.push_back(sad); q_x.push_back(x); q_y.push_back(y);
          if (q_sad.size() == NR) begin m_result(); m_st = 2; end
        end
      end
      default: begin
        e_stray = v;
        if (r) begin
          if (s) begin m_st = 1; m_clear(); end
          else m_st = 0;
        end
      end
    endcase
  endfunction

  // One clock: drive inputs, advance model, compare all outputs after the edge.
  task automatic cycle(input bit s, input bit v, input int sad, input int x,
                       input int y, input bit r);
    logic [4:0] edx, edy;
    logic       prev_valid;
    prev_valid = mv_valid;
    start    = s;
    in_valid = v;
    in_data  = {12'(sad), 4'(x), 4'(y)};
    mv_ready = r;
    m_step(s, v, sad, x, y, r);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    if (err_seq) seq_pulses++;
    if (mv_valid && !prev_valid) valid_rises++;
    check("mv_valid", 32'(mv_valid), 32'(m_st == 2));
    check("busy", 32'(busy), 32'(m_st == 1));
    check("err_stray", 32'(err_stray), 32'(e_stray));
    check("err_seq", 32'(err_seq), 32'(e_seq));
    if (m_st == 2) begin
      edx = 5'(e_dx);
      edy = 5'(e_dy);
      check("mv_dx", 32'(mv_dx), 32'(edx));
      check("mv_dy", 32'(mv_dy), 32'(edy));
      check("mv_sad", 32'(mv_sad), 32'(e_sad));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(mv_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_dx"}, 32'(mv_dx), 32'd0);
    check({tag, "_dy"}, 32'(mv_dy), 32'd0);
    check({tag, "_sad"}, 32'(mv_sad), 32'd0);
    check({tag, "_stray"}, 32'(err_stray), 32'd0);
    check({tag, "_seq"}, 32'(err_seq), 32'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check_all_zero(tag);
    m_st = 0; m_clear(); e_stray = 0; e_seq = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int rs;
    rst = 1'b1; start = 0; in_valid = 0; in_data = '0; mv_ready = 0;
    m_st = 0; seq_pulses = 0; valid_rises = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    cycle(0, 0, 0, 0, 0, 0);

    // 1: row 5 holds the minimum
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NR; i++) cycle(0, 1, (i == 5) ? 20 : 100, (i == 5) ? 3 : i, i, 0);
    check("t1_valid", 32'(mv_valid), 32'd1);
    check("t1_dx", 32'(mv_dx), 32'h1B);
    check("t1_dy", 32'(mv_dy), 32'h1D);
    check("t1_sad", 32'(mv_sad), 32'd20);
    cycle(0, 0, 0, 0, 0, 1);

    // 2: tie between rows 2 and 9, earlier row kept
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NR; i++)
      cycle(0, 1, (i == 2 || i == 9) ? 7 : 50, (i == 2) ? 8 : ((i == 9) ? 1 : 15), i, 0);
    check("t2_dx", 32'(mv_dx), 32'h00);
    check("t2_dy", 32'(mv_dy), 32'h1A);
    check("t2_sad", 32'(mv_sad), 32'd7);

    // 3: result held under backpressure with stray words and starts
    for (int i = 0; i < 10; i++) cycle(i % 3 == 1, i % 2 == 0, 1, 1, 1, 0);
    check("t3_held_sad", 32'(mv_sad), 32'd7);
    cycle(0, 0, 0, 0, 0, 1);
    check("t3_idle_busy", 32'(busy), 32'd0);

    // 4: abort after 7 words, exactly one result from the fresh 16
    valid_rises = 0;
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 1, 0, i, 0);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NR; i++) cycle(0, 1, 200 - i, 15 - i, i, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("t4_one_result", 32'(valid_rises), 32'd1);
    check("t4_sad", 32'(mv_sad), 32'd185);

    // 5: out-of-order y and all-ones SADs
    seq_pulses = 0;
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NR; i++) cycle(0, 1, 4095, i, (i == 3) ? 4 : i, 0);
    check("t5_seq_count", 32'(seq_pulses), 32'd1);
    check("t5_sad", 32'(mv_sad), 32'd4095);
    check("t5_dx", 32'(mv_dx), 32'h18);
    check("t5_dy", 32'(mv_dy), 32'h18);
    cycle(0, 0, 0, 0, 0, 1);

    // 6: reset mid-collect and mid-hold, then a clean search
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 3, 0, i, 0);
    mid_reset("rst_collect");
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NR; i++) cycle(0, 1, 9, 2, i, 0);
    mid_reset("rst_hold");
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NR; i++) cycle(0, 1, 300 + i, 4, i, 0);
    check("t6_sad", 32'(mv_sad), 32'd300);

    // 7: accept and start together
    cycle(1, 0, 0, 0, 0, 1);
    check("t7_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NR; i++) cycle(0, 1, i + 1, 12, i, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      rs = ($urandom_range(0, 3) == 0) ? 4095 : int'($urandom_range(0, 40));
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, rs,
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : (q_sad.size() % 16),
            $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
